// File: rtl/bpsk_pkt_pkg.sv
// Shared types and defaults for the UART-to-BPSK packet scheduler.
package bpsk_pkt_pkg;

    localparam int unsigned PACKET_BYTES_DEFAULT   = 23;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 50000;
    localparam int unsigned DROP_CNT_W_DEFAULT     = 8;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_e;

    typedef enum logic [1:0] {
        ASM_IDLE     = 2'd0,
        ASM_COLLECT  = 2'd1,
        ASM_WAIT_BUF = 2'd2
    } asm_state_e;

endpackage

// File: rtl/pkt_idle_timer.sv
// Idle-cycle counter for partial packets; fire_c asserts on the cycle the
// count would reach TIMEOUT_CYCLES.
module pkt_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic fire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign fire_c = en && !clr && (count == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || !en || fire_c) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_packet_scheduler.sv
// Ping-pong packet assembler between the UART receiver and the BPSK modulator.
// UART_PKT_TIMEOUT_PAD_EN: pad and commit partial packets on timeout instead of discarding them.
module uart_packet_scheduler
    import bpsk_pkt_pkg::*;
#(
    parameter int unsigned PACKET_BYTES   = PACKET_BYTES_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter logic [7:0]  PAD_BYTE       = 8'h00,
    parameter int unsigned DROP_CNT_W     = DROP_CNT_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    input  logic                      flush,
    output logic [PACKET_BYTES*8-1:0] pkt_data,
    output logic                      pkt_valid,
    input  logic                      pkt_ready,
    output logic [1:0]                fill_level,
    output logic                      overflow,
    output logic [DROP_CNT_W-1:0]     drop_count,
    output logic                      timeout_evt
);

    localparam int unsigned PKT_W = PACKET_BYTES * 8;
    localparam int unsigned IDX_W = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_BYTES - 1);
`ifdef UART_PKT_TIMEOUT_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    asm_state_e       asm_state, asm_next;
    buf_state_e       buf_st  [2];
    buf_state_e       bst_n   [2];
    logic [PKT_W-1:0] buf_data [2];
    logic [PKT_W-1:0] bdata_n  [2];
    logic             wr_sel, rd_sel, wr_sel_n, rd_sel_n;
    logic [IDX_W-1:0] byte_idx, idx_n;

    logic hs_c, target_free_c, other_free_c;
    logic accept_c, drop_c, last_c, fire_c, commit_c, discard_c;

    // Write target is free unless it still holds a packet awaiting the modulator.
    assign hs_c          = pkt_ready && (buf_st[rd_sel] == BUF_FULL) && !flush;
    assign target_free_c = (buf_st[wr_sel] != BUF_FULL) || (hs_c && (rd_sel == wr_sel));
    assign other_free_c  = (buf_st[~wr_sel] == BUF_EMPTY) || (hs_c && (rd_sel != wr_sel));
    assign accept_c      = rx_valid && !flush && target_free_c;
    assign drop_c        = rx_valid && !flush && !target_free_c;
    assign last_c        = accept_c && (byte_idx == LAST_IDX);
    assign commit_c      = last_c || (PAD_EN && fire_c);
    assign discard_c     = !PAD_EN && fire_c;

    pkt_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_c || flush),
        .en    (asm_state == ASM_COLLECT),
        .fire_c(fire_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_state <= ASM_IDLE;
        end else begin
            asm_state <= asm_next;
        end
    end

    always_comb begin
        asm_next = asm_state;
        if (flush) begin
            asm_next = ASM_IDLE;
        end else if (commit_c) begin
            asm_next = other_free_c ? ASM_IDLE : ASM_WAIT_BUF;
        end else if (accept_c) begin
            asm_next = ASM_COLLECT;
        end else if (discard_c) begin
            asm_next = ASM_IDLE;
        end else if ((asm_state == ASM_WAIT_BUF) && target_free_c) begin
            asm_next = ASM_IDLE;
        end
    end

    // Buffer, pointer and byte-index updates; handshake is applied before the write.
    always_comb begin
        bst_n[0]   = buf_st[0];
        bst_n[1]   = buf_st[1];
        bdata_n[0] = buf_data[0];
        bdata_n[1] = buf_data[1];
        wr_sel_n   = wr_sel;
        rd_sel_n   = rd_sel;
        idx_n      = byte_idx;
        if (flush) begin
            bst_n[0] = BUF_EMPTY;
            bst_n[1] = BUF_EMPTY;
            idx_n    = '0;
        end else begin
            if (hs_c) begin
                bst_n[rd_sel] = BUF_EMPTY;
                rd_sel_n      = ~rd_sel;
            end
            if (accept_c) begin
                bdata_n[wr_sel][PKT_W - 8 - 8 * 32'(byte_idx) +: 8] = rx_data;
                bst_n[wr_sel] = BUF_FILLING;
                idx_n         = byte_idx + IDX_W'(1);
            end
            if (PAD_EN && fire_c) begin
                for (int unsigned i = 0; i < PACKET_BYTES; i++) begin
                    if (i >= 32'(byte_idx)) begin
                        bdata_n[wr_sel][PKT_W - 8 - 8 * i +: 8] = PAD_BYTE;
                    end
                end
            end
            if (commit_c) begin
                bst_n[wr_sel] = BUF_FULL;
                wr_sel_n      = ~wr_sel;
                idx_n         = '0;
            end else if (discard_c) begin
                bst_n[wr_sel] = BUF_EMPTY;
                idx_n         = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_st[0]   <= BUF_EMPTY;
            buf_st[1]   <= BUF_EMPTY;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            byte_idx    <= '0;
            pkt_valid   <= 1'b0;
            pkt_data    <= '0;
            fill_level  <= 2'd0;
            overflow    <= 1'b0;
            drop_count  <= '0;
            timeout_evt <= 1'b0;
        end else begin
            buf_st[0]   <= bst_n[0];
            buf_st[1]   <= bst_n[1];
            buf_data[0] <= bdata_n[0];
            buf_data[1] <= bdata_n[1];
            wr_sel      <= wr_sel_n;
            rd_sel      <= rd_sel_n;
            byte_idx    <= idx_n;
            pkt_valid   <= (bst_n[rd_sel_n] == BUF_FULL);
            pkt_data    <= bdata_n[rd_sel_n];
            fill_level  <= 2'(bst_n[0] == BUF_FULL) + 2'(bst_n[1] == BUF_FULL);
            timeout_evt <= fire_c;
            if (flush) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end else if (drop_c) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_CNT_W'(1);
                end
            end
        end
    end

endmodule
